// File: rtl/ex_mem_stage_pkg.sv
// Shared EX/MEM definitions: default widths, NOP/enable codes, payload struct and skid-buffer states.
package ex_mem_stage_pkg;

    localparam int unsigned DEF_XLEN      = 32;
    localparam int unsigned DEF_MADDR_W   = 32;
    localparam int unsigned DEF_REGADDR_W = 5;
    localparam int unsigned DEF_ALUOP_W   = 7;
    localparam int unsigned DEF_FUNCT3_W  = 3;

    localparam logic [DEF_ALUOP_W-1:0]   NOP           = '0;
    localparam logic [DEF_FUNCT3_W-1:0]  NOP_FUNCT3    = '0;
    localparam logic                     MEM_ENABLE    = 1'b1;
    localparam logic                     MEM_DISABLE   = 1'b0;
    localparam logic                     WRITE_ENABLE  = 1'b1;
    localparam logic                     WRITE_DISABLE = 1'b0;
    localparam logic [DEF_MADDR_W-1:0]   NOP_MEM       = '0;
    localparam logic [DEF_REGADDR_W-1:0] NOP_REG_ADDR  = '0;
    localparam logic [DEF_XLEN-1:0]      ZERO_WORD     = '0;

    typedef struct packed {
        logic [DEF_ALUOP_W-1:0]   aluop;
        logic [DEF_FUNCT3_W-1:0]  alufunct3;
        logic                     me;
        logic [DEF_MADDR_W-1:0]   maddr;
        logic                     wreg;
        logic [DEF_REGADDR_W-1:0] wd;
        logic [DEF_XLEN-1:0]      wdata;
    } ex_mem_payload_t;

    localparam int unsigned EX_MEM_PAYLOAD_W = $bits(ex_mem_payload_t);

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with registered up_ready; clr (and rst) empty it to CLR_VAL.
module pipe_skid_buf
    import ex_mem_stage_pkg::*;
#(
    parameter int unsigned W       = 8,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [W-1:0] dn_data
);

    skid_state_t  state_q, state_d;
    logic [W-1:0] skid_q;
    logic         accept, consume;
    logic         load_m, move_s, load_s, drain;

    assign accept  = up_valid && up_ready;
    assign consume = dn_valid && dn_ready;

    // Next state and register-load selects
    always_comb begin
        state_d = state_q;
        load_m  = 1'b0;
        move_s  = 1'b0;
        load_s  = 1'b0;
        drain   = 1'b0;
        case (state_q)
            SKID_EMPTY: begin
                if (accept) begin
                    state_d = SKID_ONE;
                    load_m  = 1'b1;
                end
            end
            SKID_ONE: begin
                if (accept && consume) begin
                    load_m = 1'b1;
                end else if (consume) begin
                    state_d = SKID_EMPTY;
                    drain   = 1'b1;
                end else if (accept) begin
                    state_d = SKID_FULL;
                    load_s  = 1'b1;
                end
            end
            SKID_FULL: begin
                if (consume) begin
                    state_d = SKID_ONE;
                    move_s  = 1'b1;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
    end

    // A drained output register returns to CLR_VAL so no stale payload is presented
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q  <= SKID_EMPTY;
            dn_valid <= 1'b0;
            up_ready <= 1'b1;
            dn_data  <= CLR_VAL;
            skid_q   <= CLR_VAL;
        end else begin
            state_q  <= state_d;
            dn_valid <= (state_d != SKID_EMPTY);
            up_ready <= (state_d != SKID_FULL);
            if (load_m) begin
                dn_data <= up_data;
            end else if (move_s) begin
                dn_data <= skid_q;
            end else if (drain) begin
                dn_data <= CLR_VAL;
            end
            if (load_s) begin
                skid_q <= up_data;
            end
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline boundary with valid/ready skid buffering, flush squash and data-RAM chip enable.
// Optional stall counter output stall_cnt when EX_MEM_PERF_EN is defined.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int unsigned XLEN      = DEF_XLEN,
    parameter int unsigned MADDR_W   = DEF_MADDR_W,
    parameter int unsigned REGADDR_W = DEF_REGADDR_W,
    parameter int unsigned ALUOP_W   = DEF_ALUOP_W,
    parameter int unsigned FUNCT3_W  = DEF_FUNCT3_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    output logic                 ce,
    input  logic                 ex_valid,
    output logic                 ex_ready,
    input  logic [ALUOP_W-1:0]   ex_aluop,
    input  logic [FUNCT3_W-1:0]  ex_alufunct3,
    input  logic                 ex_me,
    input  logic [MADDR_W-1:0]   ex_maddr,
    input  logic                 ex_wreg,
    input  logic [REGADDR_W-1:0] ex_wd,
    input  logic [XLEN-1:0]      ex_wdata,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic [ALUOP_W-1:0]   mem_aluop,
    output logic [FUNCT3_W-1:0]  mem_alufunct3,
    output logic                 mem_me,
    output logic [MADDR_W-1:0]   mem_maddr,
    output logic                 mem_wreg,
    output logic [REGADDR_W-1:0] mem_wd,
`ifdef EX_MEM_PERF_EN
    output logic [31:0]          stall_cnt,
`endif
    output logic [XLEN-1:0]      mem_wdata
);

    localparam int unsigned PAYLOAD_W = ALUOP_W + FUNCT3_W + 1 + MADDR_W + 1 + REGADDR_W + XLEN;

    // Empty/flushed entries carry the NOP encoding, which also keeps me/wreg disabled when invalid
    localparam logic [PAYLOAD_W-1:0] NOP_PAYLOAD = {
        ALUOP_W'(NOP), FUNCT3_W'(NOP_FUNCT3), MEM_DISABLE, MADDR_W'(NOP_MEM),
        WRITE_DISABLE, REGADDR_W'(NOP_REG_ADDR), XLEN'(ZERO_WORD)
    };

    logic [PAYLOAD_W-1:0] ex_payload;
    logic [PAYLOAD_W-1:0] mem_payload;

    assign ex_payload = {ex_aluop, ex_alufunct3, ex_me, ex_maddr, ex_wreg, ex_wd, ex_wdata};
    assign {mem_aluop, mem_alufunct3, mem_me, mem_maddr, mem_wreg, mem_wd, mem_wdata} = mem_payload;

    pipe_skid_buf #(
        .W       (PAYLOAD_W),
        .CLR_VAL (NOP_PAYLOAD)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .up_valid (ex_valid),
        .up_ready (ex_ready),
        .up_data  (ex_payload),
        .dn_valid (mem_valid),
        .dn_ready (mem_ready),
        .dn_data  (mem_payload)
    );

    always_ff @(posedge clk) begin
        ce <= !rst;
    end

`ifdef EX_MEM_PERF_EN
    // Cycles MEM holds off a valid entry; only rst clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (mem_valid && !mem_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios then random traffic against a queue model.
module tb_ex_mem_stage;
    import ex_mem_stage_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst, flush, ce;
    logic                     ex_valid, ex_ready, mem_valid, mem_ready;
    logic [DEF_ALUOP_W-1:0]   ex_aluop, mem_aluop;
    logic [DEF_FUNCT3_W-1:0]  ex_alufunct3, mem_alufunct3;
    logic                     ex_me, mem_me, ex_wreg, mem_wreg;
    logic [DEF_MADDR_W-1:0]   ex_maddr, mem_maddr;
    logic [DEF_REGADDR_W-1:0] ex_wd, mem_wd;
    logic [DEF_XLEN-1:0]      ex_wdata, mem_wdata;
`ifdef EX_MEM_PERF_EN
    logic [31:0]              stall_cnt;
`endif

    ex_mem_stage dut (
        .clk (clk), .rst (rst), .flush (flush), .ce (ce),
        .ex_valid (ex_valid), .ex_ready (ex_ready),
        .ex_aluop (ex_aluop), .ex_alufunct3 (ex_alufunct3), .ex_me (ex_me),
        .ex_maddr (ex_maddr), .ex_wreg (ex_wreg), .ex_wd (ex_wd), .ex_wdata (ex_wdata),
        .mem_valid (mem_valid), .mem_ready (mem_ready),
        .mem_aluop (mem_aluop), .mem_alufunct3 (mem_alufunct3), .mem_me (mem_me),
        .mem_maddr (mem_maddr), .mem_wreg (mem_wreg), .mem_wd (mem_wd),
`ifdef EX_MEM_PERF_EN
        .stall_cnt (stall_cnt),
`endif
        .mem_wdata (mem_wdata)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: an in-order queue holding at most two beats
    ex_mem_payload_t q[$];
    logic            ce_m;
    bit              clean;
    logic [31:0]     stall_m;

    logic [EX_MEM_PAYLOAD_W-1:0] dut_pl;
    logic [EX_MEM_PAYLOAD_W-1:0] nop_pl;
    assign dut_pl = {mem_aluop, mem_alufunct3, mem_me, mem_maddr, mem_wreg, mem_wd, mem_wdata};
    assign nop_pl = {NOP, NOP_FUNCT3, MEM_DISABLE, NOP_MEM, WRITE_DISABLE, NOP_REG_ADDR, ZERO_WORD};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ex_mem_payload_t cur_in();
        ex_mem_payload_t p;
        p = '{aluop: ex_aluop, alufunct3: ex_alufunct3, me: ex_me, maddr: ex_maddr,
              wreg: ex_wreg, wd: ex_wd, wdata: ex_wdata};
        return p;
    endfunction

    task automatic model_step();
        bit cons, acc;
        if (rst) begin
            q.delete();
            clean   = 1'b1;
            ce_m    = 1'b0;
            stall_m = '0;
        end else begin
            ce_m = 1'b1;
            if (q.size() != 0 && !mem_ready && stall_m != 32'hFFFF_FFFF) stall_m++;
            if (flush) begin
                q.delete();
                clean = 1'b1;
            end else begin
                cons = (q.size() != 0) && mem_ready;
                acc  = ex_valid && (q.size() < 2);
                if (cons) void'(q.pop_front());
                if (acc) begin
                    q.push_back(cur_in());
                    clean = 1'b0;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("ce", 128'(ce), 128'(ce_m));
        chk("ex_ready", 128'(ex_ready), 128'(q.size() < 2));
        chk("mem_valid", 128'(mem_valid), 128'(q.size() != 0));
        if (q.size() != 0) begin
            chk("payload", 128'(dut_pl), 128'(q[0]));
        end else begin
            chk("idle_wreg", 128'(mem_wreg), 128'(WRITE_DISABLE));
            chk("idle_me", 128'(mem_me), 128'(MEM_DISABLE));
            if (clean) chk("nop_payload", 128'(dut_pl), 128'(nop_pl));
        end
`ifdef EX_MEM_PERF_EN
        chk("stall_cnt", 128'(stall_cnt), 128'(stall_m));
`endif
    endtask

    // Advance one clock: model sees the same inputs the DUT samples, then outputs are checked
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic [4:0] wd, input logic [31:0] wdata,
                         input logic [31:0] maddr);
        ex_valid     = v;
        ex_aluop     = 7'($urandom);
        ex_alufunct3 = 3'($urandom);
        ex_me        = $urandom_range(0, 1) != 0 ? MEM_ENABLE : MEM_DISABLE;
        ex_wreg      = $urandom_range(0, 1) != 0 ? WRITE_ENABLE : WRITE_DISABLE;
        ex_maddr     = maddr;
        ex_wd        = wd;
        ex_wdata     = wdata;
    endtask

    initial begin
`ifdef EX_MEM_PERF_EN
        logic [31:0] base;
`endif
        rst = 1'b1; flush = 1'b0; mem_ready = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 32'd0);

        // Reset held three cycles
        for (int i = 0; i < 3; i++) cycle();
        chk("rst_ce", 128'(ce), 128'(1'b0));
        chk("rst_valid", 128'(mem_valid), 128'(1'b0));
        chk("rst_wreg", 128'(mem_wreg), 128'(1'b0));
        chk("rst_ready", 128'(ex_ready), 128'(1'b1));
        rst = 1'b0;
        cycle();
        chk("ce_after_rst", 128'(ce), 128'(1'b1));

        // Back-to-back streaming, one beat per cycle with 1-cycle latency
        mem_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 5'(k), 32'(k * 16), 32'($urandom));
            cycle();
            chk("stream_wd", 128'(mem_wd), 128'(k));
            chk("stream_wdata", 128'(mem_wdata), 128'(k * 16));
            chk("stream_ready", 128'(ex_ready), 128'(1'b1));
        end
        drive(1'b0, 5'd0, 32'd0, 32'd0);
        cycle();

        // Backpressure into FULL, then ordered drain
        mem_ready = 1'b0;
        drive(1'b1, 5'd7, 32'h70, 32'h700); cycle();
        drive(1'b1, 5'd8, 32'h80, 32'h800); cycle();
        drive(1'b0, 5'd0, 32'd0, 32'd0);
        chk("full_ready", 128'(ex_ready), 128'(1'b0));
        chk("full_head", 128'(mem_wd), 128'(5'd7));
        mem_ready = 1'b1;
        cycle();
        chk("drain_second", 128'(mem_wd), 128'(5'd8));
        chk("drain_ready", 128'(ex_ready), 128'(1'b1));
        cycle();
        chk("drain_empty", 128'(mem_valid), 128'(1'b0));

        // Flush while FULL drops both held beats and the offered one
        mem_ready = 1'b0;
        drive(1'b1, 5'd4, 32'h40, 32'h400); cycle();
        drive(1'b1, 5'd5, 32'h50, 32'h500); cycle();
        flush = 1'b1;
        drive(1'b1, 5'd9, 32'h90, 32'h900);
        cycle();
        flush = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 32'd0);
        chk("flush_valid", 128'(mem_valid), 128'(1'b0));
        chk("flush_aluop", 128'(mem_aluop), 128'(NOP));
        chk("flush_wd", 128'(mem_wd), 128'(5'd0));
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("no_wd9", 128'(mem_valid && (mem_wd == 5'd9)), 128'(1'b0));
        end

        // Accept and consume in the same cycle from ONE
        mem_ready = 1'b0;
        drive(1'b1, 5'd2, 32'h20, 32'h080); cycle();
        mem_ready = 1'b1;
        drive(1'b1, 5'd3, 32'h30, 32'h100); cycle();
        chk("simul_maddr", 128'(mem_maddr), 128'(32'h100));
        chk("simul_wd", 128'(mem_wd), 128'(5'd3));
        chk("simul_ready", 128'(ex_ready), 128'(1'b1));
        drive(1'b0, 5'd0, 32'd0, 32'd0);
        cycle();

`ifdef EX_MEM_PERF_EN
        // Four stalled cycles with a valid entry
        mem_ready = 1'b0;
        drive(1'b1, 5'd6, 32'h60, 32'h600); cycle();
        drive(1'b0, 5'd0, 32'd0, 32'd0);
        base = stall_m;
        for (int i = 0; i < 4; i++) cycle();
        chk("stall4", 128'(stall_cnt), 128'(base + 32'd4));
        mem_ready = 1'b1;
        cycle();
`endif

        // Random traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom), $urandom, $urandom);
            mem_ready = $urandom_range(0, 3) != 0;
            flush     = $urandom_range(0, 15) == 0;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
